// File: rtl/rcc_rst_seq_pkg.sv
// Shared types for the reset/clock-enable sequencer: per-domain FSM state,
// counter width and the state-to-output decode used by every domain.
package rcc_rst_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_GATE   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HOLD   = 2'd3
  } dom_state_e;

  // {rst_n, clk_en} presented while a domain sits in a given state.
  // ASSERT keeps the clock running so synchronous flops capture the reset.
  function automatic logic [1:0] state_outs(input dom_state_e s);
    logic [1:0] o;
    case (s)
      ST_ASSERT: o = 2'b01;
      ST_GATE:   o = 2'b10;
      ST_RUN:    o = 2'b11;
      default:   o = 2'b00;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rcc_rst_seq_dom.sv
// One reset domain sequencer: ASSERT (reset held, clock on) -> GATE (reset
// released, clock off) -> RUN. HOLD parks the domain with reset asserted and
// clock off while its parent domain is not running.
module rcc_rst_seq_dom
  import rcc_rst_seq_pkg::*;
#(
  parameter int RST_DURATION  = 10,
  parameter int CLK_ON_DELAY  = 8,
  parameter bit RESET_TO_HOLD = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic req,
  output logic rst_n,
  output logic clk_en,
  output logic run
);

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_DURATION);
  localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(CLK_ON_DELAY);

  dom_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             rst_n_reg, clk_en_reg, run_reg;

  // Next-state and counter: hold beats req, req beats normal progression.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (hold) begin
      state_next = ST_HOLD;
      cnt_next   = '0;
    end else if (req && state_reg != ST_HOLD) begin
      // A request while parked in HOLD is dropped; the parent will restart us.
      state_next = ST_ASSERT;
      cnt_next   = RST_LOAD;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (cnt_reg <= 8'd1) begin
            if (GATE_LOAD == '0) begin
              state_next = ST_RUN;
              cnt_next   = '0;
            end else begin
              state_next = ST_GATE;
              cnt_next   = GATE_LOAD;
            end
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        ST_GATE: begin
          if (cnt_reg <= 8'd1) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 8'd1;
          end
        end
        ST_RUN: begin
          // Idle: drain toward zero and stay there.
          cnt_next = (cnt_reg != '0) ? cnt_reg - 8'd1 : '0;
        end
        default: begin
          // HOLD released: start a full reset sequence.
          state_next = ST_ASSERT;
          cnt_next   = RST_LOAD;
        end
      endcase
    end
  end

  // State, counter and registered outputs decoded from the next state so the
  // outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= RESET_TO_HOLD ? ST_HOLD : ST_ASSERT;
      cnt_reg    <= RESET_TO_HOLD ? '0 : RST_LOAD;
      rst_n_reg  <= 1'b0;
      clk_en_reg <= !RESET_TO_HOLD;
      run_reg    <= 1'b0;
    end else begin
      state_reg               <= state_next;
      cnt_reg                 <= cnt_next;
      {rst_n_reg, clk_en_reg} <= state_outs(state_next);
      run_reg                 <= (state_next == ST_RUN);
    end
  end

  assign rst_n  = rst_n_reg;
  assign clk_en = clk_en_reg;
  assign run    = run_reg;

endmodule

// File: rtl/rcc_rst_seq.sv
// Two-domain reset sequencer. D2 depends on D1: it is parked in HOLD whenever
// D1 is not running and starts its own sequence once D1 reaches RUN.
module rcc_rst_seq
  import rcc_rst_seq_pkg::*;
#(
  parameter int D1_RST_DURATION             = 10,
  parameter int D2_RST_DURATION             = 10,
  parameter int CLK_ON_AFTER_D1_RST_RELEASE = 8,
  parameter int CLK_ON_AFTER_D2_RST_RELEASE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic d1_rst_req,
  input  logic d2_rst_req,
  output logic d1_rst_n,
  output logic d1_clk_en,
  output logic d2_rst_n,
  output logic d2_clk_en,
  output logic seq_busy
);

  logic d1_run, d2_run;
  logic d2_hold;

  // D1's run flag only drops one cycle after a D1 request is taken, so the
  // request itself is folded in to park D2 on the very next cycle. This also
  // makes a simultaneous D2 request lose to the D1 request.
  assign d2_hold = !d1_run || d1_rst_req;

  rcc_rst_seq_dom #(
    .RST_DURATION  (D1_RST_DURATION),
    .CLK_ON_DELAY  (CLK_ON_AFTER_D1_RST_RELEASE),
    .RESET_TO_HOLD (1'b0)
  ) u_d1 (
    .clk    (clk),
    .rst    (rst),
    .hold   (1'b0),
    .req    (d1_rst_req),
    .rst_n  (d1_rst_n),
    .clk_en (d1_clk_en),
    .run    (d1_run)
  );

  rcc_rst_seq_dom #(
    .RST_DURATION  (D2_RST_DURATION),
    .CLK_ON_DELAY  (CLK_ON_AFTER_D2_RST_RELEASE),
    .RESET_TO_HOLD (1'b1)
  ) u_d2 (
    .clk    (clk),
    .rst    (rst),
    .hold   (d2_hold),
    .req    (d2_rst_req),
    .rst_n  (d2_rst_n),
    .clk_en (d2_clk_en),
    .run    (d2_run)
  );

  // Busy while either domain is outside RUN; both inputs are flop outputs.
  assign seq_busy = !(d1_run && d2_run);

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Testbench for rcc_rst_seq: directed vector table, hand-written corner
// sequences and a randomized run against a timeline model of the sequencer.
module tb_rcc_rst_seq;

  localparam int R1 = 10;
  localparam int G1 = 8;
  localparam int R2 = 10;
  localparam int G2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d1_rst_req = 1'b0;
  logic d2_rst_req = 1'b0;
  logic d1_rst_n, d1_clk_en, d2_rst_n, d2_clk_en, seq_busy;

  logic z_rst = 1'b1;
  logic z_d1_req = 1'b0;
  logic z_d2_req = 1'b0;
  logic z_d1_rst_n, z_d1_clk_en, z_d2_rst_n, z_d2_clk_en, z_seq_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rcc_rst_seq dut (
    .clk        (clk),
    .rst        (rst),
    .d1_rst_req (d1_rst_req),
    .d2_rst_req (d2_rst_req),
    .d1_rst_n   (d1_rst_n),
    .d1_clk_en  (d1_clk_en),
    .d2_rst_n   (d2_rst_n),
    .d2_clk_en  (d2_clk_en),
    .seq_busy   (seq_busy)
  );

  rcc_rst_seq #(.CLK_ON_AFTER_D1_RST_RELEASE(0)) dut_z (
    .clk        (clk),
    .rst        (z_rst),
    .d1_rst_req (z_d1_req),
    .d2_rst_req (z_d2_req),
    .d1_rst_n   (z_d1_rst_n),
    .d1_clk_en  (z_d1_clk_en),
    .d2_rst_n   (z_d2_rst_n),
    .d2_clk_en  (z_d2_clk_en),
    .seq_busy   (z_seq_busy)
  );

  function automatic logic [4:0] outs();
    return {d1_rst_n, d1_clk_en, d2_rst_n, d2_clk_en, seq_busy};
  endfunction

  function automatic logic [4:0] outs_z();
    return {z_d1_rst_n, z_d1_clk_en, z_d2_rst_n, z_d2_clk_en, z_seq_busy};
  endfunction

  // Timeline model: a domain that started its sequence at cycle t0 is in
  // reset for R cycles, gated for G cycles, then running. D2 is parked
  // (00) before its own start cycle.
  function automatic logic [4:0] model(int t, int g1, int a0, int b0);
    logic [1:0] p, q;
    int e;
    e = t - a0;
    if (e < R1) p = 2'b01;
    else if (e < R1 + g1) p = 2'b10;
    else p = 2'b11;
    if (t < b0) q = 2'b00;
    else begin
      e = t - b0;
      if (e < R2) q = 2'b01;
      else if (e < R2 + G2) q = 2'b10;
      else q = 2'b11;
    end
    return {p, q, ~&{p, q}};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, exp);
    end else begin
      $display("ok   %s = %0d", name, got);
    end
  endtask

  // Wait (bounded) for both domains to be running, then one quiet cycle.
  task automatic settle();
    int n;
    n = 0;
    while (seq_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("settle", {4'b0000, seq_busy}, 5'b00000);
  endtask

  typedef struct {
    logic       r1;
    logic       r2;
    int         k;
    logic [4:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  logic [4:0] cap[40];
  int cnt_a, cnt_g, cnt_a2, cnt_g2, cnt_b, n;
  int t, d1_t0, d2_t0;
  logic r1, r2;

  initial begin
    // Each entry starts from both domains running; reqs pulsed at cycle n,
    // outputs sampled at cycle n+k as {d1_rst_n,d1_clk_en,d2_rst_n,d2_clk_en,busy}.
    vecs[0]  = '{r1: 1'b0, r2: 1'b1, k: 1,  exp: 5'b11011};
    vecs[1]  = '{r1: 1'b0, r2: 1'b1, k: 10, exp: 5'b11011};
    vecs[2]  = '{r1: 1'b0, r2: 1'b1, k: 11, exp: 5'b11101};
    vecs[3]  = '{r1: 1'b0, r2: 1'b1, k: 18, exp: 5'b11101};
    vecs[4]  = '{r1: 1'b0, r2: 1'b1, k: 19, exp: 5'b11110};
    vecs[5]  = '{r1: 1'b1, r2: 1'b0, k: 1,  exp: 5'b01001};
    vecs[6]  = '{r1: 1'b1, r2: 1'b0, k: 10, exp: 5'b01001};
    vecs[7]  = '{r1: 1'b1, r2: 1'b0, k: 11, exp: 5'b10001};
    vecs[8]  = '{r1: 1'b1, r2: 1'b0, k: 19, exp: 5'b11001};
    vecs[9]  = '{r1: 1'b1, r2: 1'b0, k: 20, exp: 5'b11011};
    vecs[10] = '{r1: 1'b1, r2: 1'b0, k: 37, exp: 5'b11101};
    vecs[11] = '{r1: 1'b1, r2: 1'b1, k: 1,  exp: 5'b01001};
    vecs[12] = '{r1: 1'b1, r2: 1'b1, k: 20, exp: 5'b11011};
    vecs[13] = '{r1: 1'b1, r2: 1'b1, k: 38, exp: 5'b11110};

    // Reset state, then release and capture the power-on sequence.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", outs(), 5'b01001);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cap[i] = outs();
      @(negedge clk);
    end
    cnt_a = 0; cnt_g = 0; cnt_a2 = 0; cnt_g2 = 0; cnt_b = 0;
    for (int i = 0; i < 40; i++) begin
      if (cap[i][4:3] == 2'b01) cnt_a++;
      if (cap[i][4:3] == 2'b10) cnt_g++;
      if (cap[i][2:1] == 2'b01) cnt_a2++;
      if (cap[i][2:1] == 2'b10) cnt_g2++;
      if (cap[i][0]) cnt_b++;
    end
    check_int("por_d1_assert", cnt_a, 10);
    check_int("por_d1_gate", cnt_g, 8);
    check_int("por_d2_assert", cnt_a2, 10);
    check_int("por_d2_gate", cnt_g2, 8);
    check_int("por_busy", cnt_b, 37);
    check("por_d1_run_first", cap[18], 5'b11001);
    check("por_d2_start", cap[19], 5'b11011);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      settle();
      d1_rst_req = vecs[i].r1;
      d2_rst_req = vecs[i].r2;
      @(negedge clk);
      d1_rst_req = 1'b0;
      d2_rst_req = 1'b0;
      for (int j = 1; j < vecs[i].k; j++) @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      $display("vec%0d r1=%0b r2=%0b k=%0d outs=%b", i, vecs[i].r1, vecs[i].r2, vecs[i].k, outs());
    end

    // D2 request on the 5th ASSERT cycle restarts the full duration.
    settle();
    d2_rst_req = 1'b1;
    @(negedge clk);
    d2_rst_req = 1'b0;
    cnt_a = 0;
    n = 0;
    while (n < 60) begin
      if (d2_rst_n == 1'b0 && d2_clk_en == 1'b1) begin
        cnt_a++;
        if (cnt_a == 5) d2_rst_req = 1'b1;
      end else if (cnt_a > 0) begin
        break;
      end
      @(negedge clk);
      d2_rst_req = 1'b0;
      n++;
    end
    check_int("d2_assert_restart", cnt_a, 15);

    // D1 request while D2 is gated parks D2 immediately.
    settle();
    d2_rst_req = 1'b1;
    @(negedge clk);
    d2_rst_req = 1'b0;
    n = 0;
    while (!(d2_rst_n && !d2_clk_en) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_d2_gate", outs(), 5'b11101);
    d1_rst_req = 1'b1;
    @(negedge clk);
    d1_rst_req = 1'b0;
    check("d1_req_in_d2_gate", outs(), 5'b01001);
    n = 1;
    while (seq_busy && n < 80) begin
      @(negedge clk);
      n++;
    end
    check_int("d1_restart_len", n, 38);

    // Zero D1 gate delay: async reset mid-D2-GATE, then no D1 GATE cycle.
    @(negedge clk);
    z_rst = 1'b0;
    for (int tt = 0; tt < 25; tt++) begin
      if (tt == 9 || tt == 10 || tt == 24)
        check($sformatf("z_t%0d", tt), outs_z(), model(tt, 0, 0, R1 + 1));
      @(negedge clk);
    end
    #1;
    z_rst = 1'b1;
    #1;
    check("z_async_reset", outs_z(), 5'b01001);
    @(negedge clk);
    z_rst = 1'b0;
    cnt_g = 0;
    for (int tt = 0; tt < 14; tt++) begin
      if (outs_z() !== model(tt, 0, 0, R1 + 1)) begin
        bad++;
        $display("FAIL z_seq t=%0d: got=%b want=%b", tt, outs_z(), model(tt, 0, 0, R1 + 1));
      end
      total++;
      if (z_d1_rst_n && !z_d1_clk_en) cnt_g++;
      @(negedge clk);
    end
    check_int("z_d1_gate_cycles", cnt_g, 0);

    // Randomized requests and resets against the timeline model.
    rst = 1'b1;
    #1;
    check("rand_async_reset", outs(), 5'b01001);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    d1_t0 = 0;
    d2_t0 = R1 + G1 + 1;
    for (int c = 0; c < 4000; c++) begin
      if (outs() !== model(t, G1, d1_t0, d2_t0)) begin
        bad++;
        $display("FAIL rand c=%0d t=%0d: got=%b want=%b", c, t, outs(), model(t, G1, d1_t0, d2_t0));
      end
      total++;
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_mid_reset", outs(), 5'b01001);
        @(negedge clk);
        rst = 1'b0;
        t = 0;
        d1_t0 = 0;
        d2_t0 = R1 + G1 + 1;
      end else begin
        r1 = ($urandom_range(0, 79) == 0);
        r2 = ($urandom_range(0, 24) == 0);
        d1_rst_req = r1;
        d2_rst_req = r2;
        if (r1) begin
          d1_t0 = t + 1;
          d2_t0 = t + 1 + R1 + G1 + 1;
        end else if (r2 && t >= d2_t0) begin
          d2_t0 = t + 1;
        end
        @(negedge clk);
        d1_rst_req = 1'b0;
        d2_rst_req = 1'b0;
        t++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
